// File: rtl/alu_ex_stage.sv
// Execute stage around an external ALU: holds the ID/EX register, builds the
// ALU operands (register data, extended immediate, one-hop forwarding from
// EX/MEM) and registers the ALU result into EX/MEM with valid/ready on both
// sides and a synchronous flush.
module alu_ex_stage #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs_addr,
  input  logic [AW-1:0] in_rt_addr,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [15:0]   in_imm16,
  input  logic          in_use_imm,
  input  logic          in_sign_ext,
  input  logic [5:0]    in_alu_op,
  input  logic          in_wreg,
  input  logic [AW-1:0] in_waddr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alu_op,
  input  logic [DW-1:0] alu_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_result,
  output logic          out_wreg,
  output logic [AW-1:0] out_waddr
);

  // ID/EX register
  logic          r_s1_valid;
  logic [AW-1:0] r_s1_rs_addr;
  logic [AW-1:0] r_s1_rt_addr;
  logic [DW-1:0] r_s1_rs_data;
  logic [DW-1:0] r_s1_rt_data;
  logic [DW-1:0] r_s1_ext;
  logic          r_s1_use_imm;
  logic [5:0]    r_s1_alu_op;
  logic          r_s1_wreg;
  logic [AW-1:0] r_s1_waddr;

  // EX/MEM register
  logic          r_s2_valid;
  logic [DW-1:0] r_out_result;
  logic          r_out_wreg;
  logic [AW-1:0] r_out_waddr;

  logic          w_s2_adv;
  logic          w_accept;
  logic          w_fwd_rs;
  logic          w_fwd_rt;
  logic [DW-1:0] w_ext;

  assign w_s2_adv = r_s1_valid & (~r_s2_valid | out_ready);
  // Flush forces ready so decode never stalls on an op that is about to be dropped.
  assign in_ready = flush | ~r_s1_valid | w_s2_adv;
  assign w_accept = in_valid & in_ready & ~flush;

  assign out_valid  = r_s2_valid;
  assign out_result = r_out_result;
  assign out_wreg   = r_out_wreg;
  assign out_waddr  = r_out_waddr;

  // Immediate extension, resolved at acceptance time
  always_comb begin
    w_ext = {{(DW-16){in_sign_ext & in_imm16[15]}}, in_imm16};
  end

  // Operand formation with forwarding from EX/MEM; register 0 is never forwarded
  always_comb begin
    w_fwd_rs = r_s2_valid & r_out_wreg & (r_out_waddr != '0) &
               (r_out_waddr == r_s1_rs_addr);
    w_fwd_rt = r_s2_valid & r_out_wreg & (r_out_waddr != '0) &
               (r_out_waddr == r_s1_rt_addr) & ~r_s1_use_imm;
    alu_a    = w_fwd_rs ? r_out_result : r_s1_rs_data;
    alu_b    = r_s1_use_imm ? r_s1_ext : (w_fwd_rt ? r_out_result : r_s1_rt_data);
    alu_op   = r_s1_alu_op;
  end

  // ID/EX capture: latch fields on accept, empty when the op moves on
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s1_valid   <= 1'b0;
      r_s1_rs_addr <= '0;
      r_s1_rt_addr <= '0;
      r_s1_rs_data <= '0;
      r_s1_rt_data <= '0;
      r_s1_ext     <= '0;
      r_s1_use_imm <= 1'b0;
      r_s1_alu_op  <= '0;
      r_s1_wreg    <= 1'b0;
      r_s1_waddr   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid   <= 1'b1;
      r_s1_rs_addr <= in_rs_addr;
      r_s1_rt_addr <= in_rt_addr;
      r_s1_rs_data <= in_rs_data;
      r_s1_rt_data <= in_rt_data;
      r_s1_ext     <= w_ext;
      r_s1_use_imm <= in_use_imm;
      r_s1_alu_op  <= in_alu_op;
      r_s1_wreg    <= in_wreg;
      r_s1_waddr   <= in_waddr;
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // EX/MEM capture: register ALU result on advance, drain on consume
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_s2_valid   <= 1'b0;
      r_out_result <= '0;
      r_out_wreg   <= 1'b0;
      r_out_waddr  <= '0;
    end else if (flush) begin
      // Result and address are left as-is; clearing wreg alone stops forwarding.
      r_s2_valid <= 1'b0;
      r_out_wreg <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid   <= 1'b1;
      r_out_result <= alu_y;
      r_out_wreg   <= r_s1_wreg;
      r_out_waddr  <= r_s1_waddr;
    end else if (r_s2_valid & out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Bench for alu_ex_stage: hosts a small ALU model on the alu_* ports, drives
// ops through a scoreboard queue and checks each result as it leaves EX/MEM.
module tb_alu_ex_stage;

  localparam logic [5:0] OP_AND = 6'b000100;
  localparam logic [5:0] OP_OR  = 6'b000101;
  localparam logic [5:0] OP_XOR = 6'b000110;
  localparam logic [5:0] OP_LUI = 6'b001010;
  localparam logic [5:0] OP_ADD = 6'b100000;

  typedef struct packed {
    logic [31:0] res;
    logic        wreg;
    logic [4:0]  waddr;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs_addr = '0;
  logic [4:0]  in_rt_addr = '0;
  logic [31:0] in_rs_data = '0;
  logic [31:0] in_rt_data = '0;
  logic [15:0] in_imm16 = '0;
  logic        in_use_imm = 1'b0;
  logic        in_sign_ext = 1'b0;
  logic [5:0]  in_alu_op = '0;
  logic        in_wreg = 1'b0;
  logic [4:0]  in_waddr = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_op;
  logic [31:0] alu_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic        out_wreg;
  logic [4:0]  out_waddr;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  exp_t pend;

  alu_ex_stage #(.DW(32), .AW(5)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
    .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm16(in_imm16), .in_use_imm(in_use_imm), .in_sign_ext(in_sign_ext),
    .in_alu_op(in_alu_op), .in_wreg(in_wreg), .in_waddr(in_waddr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_wreg(out_wreg), .out_waddr(out_waddr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [5:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_LUI:  return {b[15:0], 16'h0000};
      OP_ADD:  return a + b;
      default: return 32'h0;
    endcase
  endfunction

  always_comb alu_y = alu_model(alu_op, alu_a, alu_b);

  // Scoreboard: compare every consumed output against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (resetn && !flush && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got res=%h wreg=%b waddr=%0d, required no output",
                 out_result, out_wreg, out_waddr);
      end else begin
        e = sb.pop_front();
        if ({out_result, out_wreg, out_waddr} !== e) begin
          n_err++;
          $display("FAIL sb_result: got res=%h wreg=%b waddr=%0d, required res=%h wreg=%b waddr=%0d",
                   out_result, out_wreg, out_waddr, e.res, e.wreg, e.waddr);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rs_a, input logic [31:0] rs_d,
                        input logic [4:0] rt_a, input logic [31:0] rt_d,
                        input logic [15:0] imm, input logic use_imm, input logic sext,
                        input logic [5:0] op, input logic wreg, input logic [4:0] waddr,
                        input logic [31:0] exp_res);
    in_rs_addr  = rs_a;
    in_rs_data  = rs_d;
    in_rt_addr  = rt_a;
    in_rt_data  = rt_d;
    in_imm16    = imm;
    in_use_imm  = use_imm;
    in_sign_ext = sext;
    in_alu_op   = op;
    in_wreg     = wreg;
    in_waddr    = waddr;
    in_valid    = 1'b1;
    pend        = '{res: exp_res, wreg: wreg, waddr: waddr};
  endtask

  // Waits (bounded) for the offered op to be taken; returns just after that edge
  task automatic wait_accept(input string name);
    bit acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(pend);
        acc = 1;
      end
      @(posedge clk);
      #1;
      if (acc) break;
    end
    in_valid = 1'b0;
    n_vec++;
    if (!acc) begin
      n_err++;
      $display("FAIL %s_accept: got in_ready=0 for 20 cycles, required acceptance", name);
    end
  endtask

  task automatic send(input logic [4:0] rs_a, input logic [31:0] rs_d,
                      input logic [4:0] rt_a, input logic [31:0] rt_d,
                      input logic [15:0] imm, input logic use_imm, input logic sext,
                      input logic [5:0] op, input logic wreg, input logic [4:0] waddr,
                      input logic [31:0] exp_res, input string name);
    set_op(rs_a, rs_d, rt_a, rt_d, imm, use_imm, sext, op, wreg, waddr, exp_res);
    wait_accept(name);
  endtask

  task automatic test_reset();
    idle(2);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0 ||
        out_wreg !== 1'b0 || out_waddr !== 5'd0) begin
      n_err++;
      $display("FAIL por_state: got valid=%b ready=%b res=%h wreg=%b waddr=%0d, required 0 1 0 0 0",
               out_valid, in_ready, out_result, out_wreg, out_waddr);
    end
    n_vec++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 6'h0) begin
      n_err++;
      $display("FAIL por_alu: got a=%h b=%h op=%h, required 0 0 0", alu_a, alu_b, alu_op);
    end
    resetn = 1'b1;
    idle(1);
    // fill both stages, then reset asynchronously in mid-cycle
    out_ready = 1'b0;
    send(5'd1, 32'h11, 5'd0, 32'h0, 16'h0001, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd7, 32'h12, "rst_op1");
    send(5'd2, 32'h20, 5'd0, 32'h0, 16'h0002, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd8, 32'h22, "rst_op2");
    #3 resetn = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%b ready=%b res=%h, required 0 1 0",
               out_valid, in_ready, out_result);
    end
    n_vec++;
    if (alu_a !== 32'h0 || alu_b !== 32'h0 || alu_op !== 6'h0 || out_wreg !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_alu: got a=%h b=%h op=%h wreg=%b, required 0 0 0 0",
               alu_a, alu_b, alu_op, out_wreg);
    end
    sb.delete();
    out_ready = 1'b1;
    idle(1);
    #2 resetn = 1'b1;
    idle(2);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_discard: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_xori();
    idle(2);
    send(5'd1, 32'h0000F0F0, 5'd0, 32'h0, 16'h00FF, 1'b1, 1'b0, OP_XOR, 1'b1, 5'd2,
         32'h0000F00F, "xori");
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL xori_early: got out_valid=%b one cycle after accept, required 0", out_valid);
    end
    idle(1);
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000F00F) begin
      n_err++;
      $display("FAIL xori_latency: got valid=%b res=%h, required 1 0000f00f", out_valid, out_result);
    end
    idle(3);
  endtask

  task automatic test_imm_ext();
    send(5'd0, 32'h0, 5'd0, 32'h0, 16'h8001, 1'b1, 1'b0, OP_LUI, 1'b1, 5'd5, 32'h80010000, "lui_zx");
    send(5'd0, 32'h0, 5'd0, 32'h0, 16'h8001, 1'b1, 1'b1, OP_LUI, 1'b1, 5'd6, 32'h80010000, "lui_sx");
    send(5'd1, 32'h0, 5'd0, 32'h0, 16'h8000, 1'b1, 1'b1, OP_XOR, 1'b1, 5'd9, 32'hFFFF8000, "xor_sx");
    send(5'd1, 32'h0, 5'd0, 32'h0, 16'h8000, 1'b1, 1'b0, OP_XOR, 1'b1, 5'd9, 32'h00008000, "xor_zx");
    send(5'd1, 32'h0, 5'd0, 32'h0, 16'h7FFF, 1'b1, 1'b1, OP_XOR, 1'b1, 5'd9, 32'h00007FFF, "xor_sx_pos");
    idle(4);
  endtask

  task automatic test_forward();
    // $3 = $1 | $2 ; $4 = $5 & $3 (rt stale) ; $6 = $4 | 0xF0 (rs stale)
    send(5'd1, 32'h000000FF, 5'd2, 32'h0000FF00, 16'h0, 1'b0, 1'b0, OP_OR, 1'b1, 5'd3,
         32'h0000FFFF, "fwd_p");
    send(5'd5, 32'h00000F0F, 5'd3, 32'hDEADBEEF, 16'h0, 1'b0, 1'b0, OP_AND, 1'b1, 5'd4,
         32'h00000F0F, "fwd_rt");
    send(5'd4, 32'h12345678, 5'd0, 32'h0, 16'h00F0, 1'b1, 1'b0, OP_OR, 1'b1, 5'd6,
         32'h00000FFF, "fwd_rs");
    // use_imm: rt matches the producer but b must still be the immediate
    send(5'd7, 32'h00000001, 5'd6, 32'h00005555, 16'h0002, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd8,
         32'h00000003, "fwd_imm");
    // destination $0 must never be forwarded
    send(5'd1, 32'h000000FF, 5'd2, 32'h0000FF00, 16'h0, 1'b0, 1'b0, OP_OR, 1'b1, 5'd0,
         32'h0000FFFF, "zero_p1");
    send(5'd5, 32'h00000F0F, 5'd0, 32'h0, 16'h0, 1'b0, 1'b0, OP_OR, 1'b1, 5'd0,
         32'h00000F0F, "zero_rt");
    send(5'd0, 32'h0, 5'd0, 32'h0, 16'h0001, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd10,
         32'h00000001, "zero_rs");
    // wreg=0 producer is not forwarded either
    send(5'd1, 32'h00000010, 5'd0, 32'h0, 16'h0010, 1'b1, 1'b0, OP_ADD, 1'b0, 5'd11,
         32'h00000020, "nowr_p");
    send(5'd11, 32'h00000003, 5'd0, 32'h0, 16'h0001, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd12,
         32'h00000004, "nowr_c");
    idle(4);
  endtask

  task automatic test_backpressure();
    logic [31:0] s_res;
    logic        s_wreg;
    logic [4:0]  s_waddr;
    out_ready = 1'b0;
    send(5'd8, 32'h00000010, 5'd0, 32'h0, 16'h0005, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd9,
         32'h00000015, "bp1");
    send(5'd10, 32'h00000100, 5'd11, 32'h00000023, 16'h0, 1'b0, 1'b0, OP_ADD, 1'b1, 5'd12,
         32'h00000123, "bp2");
    // rs of op3 is op2's destination: forwarded once s2 holds op2
    set_op(5'd12, 32'hAAAA0000, 5'd0, 32'h0, 16'hFFFF, 1'b1, 1'b0, OP_XOR, 1'b0, 5'd14,
           32'h0000FEDC);
    s_res = out_result;
    s_wreg = out_wreg;
    s_waddr = out_waddr;
    n_vec++;
    if (out_valid !== 1'b1 || s_res !== 32'h00000015 || s_waddr !== 5'd9) begin
      n_err++;
      $display("FAIL bp_head: got valid=%b res=%h waddr=%0d, required 1 00000015 9",
               out_valid, s_res, s_waddr);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_ready: cycle %0d got in_ready=%b, required 0", i, in_ready);
      end
      n_vec++;
      if (out_valid !== 1'b1 || out_result !== s_res || out_wreg !== s_wreg || out_waddr !== s_waddr) begin
        n_err++;
        $display("FAIL bp_stable: cycle %0d got valid=%b res=%h wreg=%b waddr=%0d, required 1 %h %b %0d",
                 i, out_valid, out_result, out_wreg, out_waddr, s_res, s_wreg, s_waddr);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_accept("bp3");
    idle(4);
  endtask

  task automatic test_flush();
    logic [31:0] s_res;
    out_ready = 1'b0;
    send(5'd1, 32'h1, 5'd0, 32'h0, 16'h0001, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd20, 32'h2, "fl_a");
    send(5'd2, 32'h2, 5'd0, 32'h0, 16'h0002, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd21, 32'h4, "fl_b");
    s_res = out_result;
    set_op(5'd0, 32'h0, 5'd0, 32'h0, 16'h7777, 1'b1, 1'b0, OP_OR, 1'b1, 5'd22, 32'h7777);
    flush = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_ready: got in_ready=%b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    n_vec++;
    if (out_valid !== 1'b0 || out_wreg !== 1'b0 || out_result !== s_res || out_waddr !== 5'd20) begin
      n_err++;
      $display("FAIL flush_state: got valid=%b wreg=%b res=%h waddr=%0d, required 0 0 %h 20",
               out_valid, out_wreg, out_result, out_waddr, s_res);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL flush_drop: cycle %0d got out_valid=%b res=%h, required 0", i, out_valid, out_result);
      end
    end
    @(posedge clk);
    #1;
    send(5'd3, 32'h30, 5'd0, 32'h0, 16'h0003, 1'b1, 1'b0, OP_ADD, 1'b1, 5'd23, 32'h33, "fl_d");
    idle(1);
    n_vec++;
    if (out_valid !== 1'b1 || out_result !== 32'h33 || out_waddr !== 5'd23) begin
      n_err++;
      $display("FAIL flush_next: got valid=%b res=%h waddr=%0d, required 1 00000033 23",
               out_valid, out_result, out_waddr);
    end
    idle(3);
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = $urandom;
      send(5'd16, a, 5'd0, 32'h0, 16'(i * 3 + 1), 1'b1, 1'b0, OP_ADD, 1'b1, 5'd17,
           a + 32'(i * 3 + 1), "b2b");
    end
    idle(4);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results still outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_xori();
    test_imm_ext();
    test_forward();
    test_backpressure();
    test_flush();
    test_back_to_back();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
